mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 79 +++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and LSU onto one memory port, one transaction outstanding, LSU priority bounded by STARVE_MAX.
// Ports:
//   clk_i, rst_i (async, active-high)
//   if_req_i/if_addr_i -> if_gnt_o/if_rvalid_o/if_rdata_o   : fetch read port
//   ls_req_i/ls_we_i/ls_be_i/ls_addr_i/ls_wdata_i -> ls_gnt_o/ls_rvalid_o/ls_rdata_o : LSU port
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o <- mem_gnt_i/mem_rvalid_i/mem_rdata_i : shared memory
//   flush_i : discard any outstanding fetch response
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        flush_i
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  typedef enum logic {IDLE, WAIT_RSP} state_t;
  state_t state, state_nxt;
  logic owner_ls, owner_ls_nxt, drop, drop_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic idle, ls_win, if_win, rsp;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= IDLE;
      owner_ls   <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner_ls   <= owner_ls_nxt;
      drop       <= drop_nxt;
      starve_cnt <= starve_nxt;
    end
  always_comb begin
    idle        = state == IDLE;
    ls_win      = ls_req_i && (!if_req_i || starve_cnt < SMAX);
    if_win      = if_req_i && !ls_win;
    rsp         = !idle && mem_rvalid_i;
    mem_req_o   = idle && (if_req_i || ls_req_i);
    mem_we_o    = idle && ls_win && ls_we_i;
    mem_be_o    = !idle ? 4'h0 : ls_win ? ls_be_i : if_win ? 4'hF : 4'h0;
    mem_addr_o  = !idle ? 32'h0 : ls_win ? ls_addr_i : if_win ? if_addr_i : 32'h0;
    mem_wdata_o = (idle && ls_win) ? ls_wdata_i : 32'h0;
    if_gnt_o    = idle && if_win && mem_gnt_i;
    ls_gnt_o    = idle && ls_win && mem_gnt_i;
    // a flush landing on the response cycle itself must also hide the data
    if_rvalid_o = rsp && !owner_ls && !drop && !flush_i;
    ls_rvalid_o = rsp && owner_ls;
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
    state_nxt   = (if_gnt_o || ls_gnt_o) ? WAIT_RSP : rsp ? IDLE : state;
    owner_ls_nxt = if_gnt_o ? 1'b0 : ls_gnt_o ? 1'b1 : owner_ls;
    starve_nxt  = if_gnt_o ? '0 :
                  (ls_gnt_o && if_req_i && starve_cnt < SMAX) ? starve_cnt + 1'b1 : starve_cnt;
    drop_nxt    = rsp ? 1'b0 :
                  ((!idle && !owner_ls && flush_i) || (if_gnt_o && flush_i)) ? 1'b1 : drop;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_i = 1'b1;
  logic if_req_i = 0, ls_req_i = 0, ls_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0, flush_i = 0;
  logic [3:0] ls_be_i = 0;
  logic [31:0] if_addr_i = 0, ls_addr_i = 0, ls_wdata_i = 0, mem_rdata_i = 0;
  logic if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .flush_i(flush_i)
  );
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic exp_ls;
    logic [31:0] exp_sc;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_if_gnt", if_gnt_o, 1'b0);
    chk1("rst_ls_gnt", ls_gnt_o, 1'b0);
    chk32("rst_starve", 32'(dut.starve_cnt), 32'd0);
    chk32("rst_addr", mem_addr_o, 32'h0);
    rst_i = 1'b0;
    // lone fetch
    if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
    #1;
    chk1("f_mem_req", mem_req_o, 1'b1);
    chk32("f_addr", mem_addr_o, 32'h100);
    chk32("f_be", {28'h0, mem_be_o}, 32'hF);
    chk1("f_we", mem_we_o, 1'b0);
    chk1("f_if_gnt", if_gnt_o, 1'b1);
    chk1("f_ls_gnt", ls_gnt_o, 1'b0);
    tick;
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    #1;
    chk1("f_wait_req", mem_req_o, 1'b0);
    chk1("f_rvalid", if_rvalid_o, 1'b1);
    chk32("f_rdata", if_rdata_o, 32'h13);
    chk1("f_ls_rvalid", ls_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0;
    // back-pressure on LSU
    ls_req_i = 1; ls_addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_mem_req", mem_req_o, 1'b1);
      chk1("bp_ls_gnt", ls_gnt_o, 1'b0);
      tick;
    end
    mem_gnt_i = 1;
    #1;
    chk1("bp_ls_gnt4", ls_gnt_o, 1'b1);
    tick;
    ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAB;
    #1;
    chk1("bp_ls_rvalid", ls_rvalid_o, 1'b1);
    chk32("bp_ls_rdata", ls_rdata_o, 32'hAB);
    chk1("bp_if_rvalid", if_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0;
    chk32("bp_starve", 32'(dut.starve_cnt), 32'd0);
    // LSU store
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'h3; ls_addr_i = 32'h2000; ls_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1;
    #1;
    chk1("st_we", mem_we_o, 1'b1);
    chk32("st_be", {28'h0, mem_be_o}, 32'h3);
    chk32("st_addr", mem_addr_o, 32'h2000);
    chk32("st_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk1("st_ls_gnt", ls_gnt_o, 1'b1);
    chk1("st_if_gnt", if_gnt_o, 1'b0);
    tick;
    ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    #1;
    chk1("st_ack", ls_rvalid_o, 1'b1);
    chk1("st_if_rvalid", if_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0;
    // contention with zero-wait memory
    if_req_i = 1; if_addr_i = 32'h200; ls_req_i = 1; ls_be_i = 4'hF; ls_addr_i = 32'h3000; mem_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      exp_ls = (i != 4);
      exp_sc = (i < 4) ? 32'(i + 1) : (i == 4) ? 32'd0 : 32'd1;
      mem_rvalid_i = 0;
      #1;
      chk1("ct_ls_gnt", ls_gnt_o, exp_ls);
      chk1("ct_if_gnt", if_gnt_o, !exp_ls);
      chk32("ct_addr", mem_addr_o, exp_ls ? 32'h3000 : 32'h200);
      tick;
      chk32("ct_starve", 32'(dut.starve_cnt), exp_sc);
      mem_rvalid_i = 1;
      #1;
      chk1("ct_wait_req", mem_req_o, 1'b0);
      chk1("ct_rvalid", exp_ls ? ls_rvalid_o : if_rvalid_o, 1'b1);
      tick;
    end
    mem_rvalid_i = 0; ls_req_i = 0;
    // flush one cycle after fetch grant, response three cycles later
    if_addr_i = 32'h300;
    #1;
    chk1("fl_if_gnt", if_gnt_o, 1'b1);
    tick;
    if_req_i = 0; mem_gnt_i = 0; flush_i = 1;
    tick;
    flush_i = 0;
    tick;
    #1;
    chk1("fl_wait_req", mem_req_o, 1'b0);
    tick;
    mem_rvalid_i = 1;
    #1;
    chk1("fl_if_rvalid", if_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0; if_req_i = 1; mem_gnt_i = 1;
    #1;
    chk1("fl_idle_gnt", if_gnt_o, 1'b1);
    tick;
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    #1;
    chk1("fl_next_rvalid", if_rvalid_o, 1'b1);
    tick;
    // flush coincident with response
    mem_rvalid_i = 0; if_req_i = 1; mem_gnt_i = 1;
    tick;
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; flush_i = 1;
    #1;
    chk1("flc_if_rvalid", if_rvalid_o, 1'b0);
    tick;
    // flush on the fetch grant cycle
    mem_rvalid_i = 0; if_req_i = 1; mem_gnt_i = 1; flush_i = 1;
    tick;
    if_req_i = 0; mem_gnt_i = 0; flush_i = 0; mem_rvalid_i = 1;
    #1;
    chk1("flg_if_rvalid", if_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0;
    // async reset mid-transaction
    if_req_i = 1; ls_req_i = 1; mem_gnt_i = 1;
    tick;
    mem_gnt_i = 0;
    chk32("rs_starve_pre", 32'(dut.starve_cnt), 32'd1);
    #1;
    chk1("rs_wait_req", mem_req_o, 1'b0);
    rst_i = 1;
    #1;
    chk1("rs_async_idle", mem_req_o, 1'b1);
    chk32("rs_async_starve", 32'(dut.starve_cnt), 32'd0);
    rst_i = 0; if_req_i = 0; ls_req_i = 0; mem_rvalid_i = 1;
    #1;
    chk1("rs_stray_if", if_rvalid_o, 1'b0);
    chk1("rs_stray_ls", ls_rvalid_o, 1'b0);
    tick;
    mem_rvalid_i = 0; ls_req_i = 1; mem_gnt_i = 1;
    #1;
    chk1("rs_still_idle", ls_gnt_o, 1'b1);
    tick;
    ls_req_i = 0; mem_gnt_i = 0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
